vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 16, meaning the shared RAM address width.
REQ-002 The block SHALL have parameter VID_AW, default 13, meaning the video fetch address width.
REQ-003 The block SHALL have parameter CPU_MAX_WAIT, default 6, meaning the number of consecutive cycles of CPU stall after which the CPU wins over video.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-008 cpu_we  in  1  1=write, 0=read; stable while cpu_req is high.
REQ-009 cpu_addr  in  RAM_AW  CPU RAM address; stable while cpu_req is high.
REQ-010 cpu_wdata  in  8  write data.
REQ-011 cpu_rdata  out  8  read data, valid in the cpu_ack cycle.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 cpu_wait_n  out  1  low while the CPU is stalled, for the CPU wait_n input.
REQ-014 vid_req  in  1  video fetch request, level, held until vid_valid.
REQ-015 vid_addr  in  VID_AW  video address, zero-extended to RAM_AW.
REQ-016 vid_rdata  out  8  fetched byte, valid in the vid_valid cycle.
REQ-017 vid_valid  out  1  one-cycle completion pulse.
REQ-018 ram_en, ram_we  out  1 each  RAM port enable and write strobe, registered.
REQ-019 ram_addr  out  RAM_AW; ram_wdata  out  8  registered RAM port address and data.
REQ-020 ram_rdata  in  8  RAM read data, valid one cycle after ram_en.

Function
REQ-021 The FSM SHALL have three states. IDLE: no access. ISSUE: ram_en=1 for the granted requester. DATA: ram_rdata is captured and ack/valid is pulsed.
REQ-022 FSM transitions SHALL be IDLE->ISSUE on any grant, ISSUE->DATA always, DATA->ISSUE if a new grant is made, and DATA->IDLE otherwise.
REQ-023 The block SHALL issue at most one RAM access per two cycles: the request is sampled at edge k, ram_en is high during k..k+1, and ack/valid is high during k+2..k+3 with the data registered.
REQ-024 Arbitration SHALL occur only in IDLE or DATA; video SHALL have priority unless the starvation counter equals CPU_MAX_WAIT, in which case the CPU SHALL be granted.
REQ-025 The starvation counter SHALL increment each cycle cpu_req=1 and the CPU is not granted, saturate at CPU_MAX_WAIT, and clear on CPU grant or when cpu_req=0.
REQ-026 A requester whose ack/valid is high in the current cycle SHALL NOT be eligible at the edge ending that cycle.
REQ-027 cpu_wait_n SHALL equal NOT(cpu_req AND NOT cpu_ack).
REQ-028 For a CPU write, ram_we=1 SHALL be driven only in ISSUE, and cpu_ack SHALL still pulse in DATA, with cpu_rdata holding its previous value.
REQ-029 Video accesses SHALL always have ram_we=0.
REQ-030 For simultaneous cpu_req and vid_req with the counter below CPU_MAX_WAIT, video SHALL be served first and the CPU next.
REQ-031 A request dropped before grant SHALL be ignored; a request dropped after grant SHALL still complete with ack/valid.

Reset
REQ-032 On reset_n=0, the block SHALL asynchronously force the FSM to IDLE and the counter to 0, and drive ram_en, ram_we, cpu_ack and vid_valid to 0, cpu_wait_n to 1 when cpu_req=0, and all data/address outputs to 0.
REQ-033 An access in flight when reset is asserted SHALL be abandoned with no ack.

Structure
REQ-034 Package vram_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, DATA), the grant-owner enum (NONE, CPU, VID) and the parameter defaults.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Scenario: CPU read only, cpu_addr=0x1800, RAM holds 0xA5 -> ram_en high 1 cycle, cpu_ack 2 cycles after the grant edge, cpu_rdata=0xA5, cpu_wait_n low for 2 cycles.
REQ-037 Scenario: CPU write, 0x0123<-0x5A, then read back -> ram_we pulses once with ram_addr=0x0123, and the readback returns 0x5A.
REQ-038 Scenario: cpu_req and vid_req rise together with vid_addr=0x0000 -> vid_valid precedes cpu_ack by exactly 2 cycles.
REQ-039 Scenario: vid_req held continuously and cpu_req held -> the CPU is granted once the counter reaches 6 and is never stalled beyond 6 cycles plus the in-flight access.
REQ-040 Scenario: assert reset_n=0 during ISSUE of a CPU read -> no cpu_ack, all outputs reset, FSM in IDLE; after release a new request completes normally.
REQ-041 Scenario: vid_req dropped in the cycle after its grant -> vid_valid still pulses once, and no second video access occurs.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and parameter defaults for the VRAM arbiter.
package vram_arb_pkg;

  // Default geometry and starvation limit
  localparam int RAM_AW_DEFAULT       = 16;
  localparam int VID_AW_DEFAULT       = 13;
  localparam int CPU_MAX_WAIT_DEFAULT = 6;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_e;

  // Owner of the access currently in flight (or being granted)
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    VID  = 2'd2
  } owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester (CPU / video) arbiter for a single-port synchronous RAM.
// One RAM access per two cycles: ISSUE drives the RAM port, DATA waits for
// the read data, which is registered together with the ack/valid pulse.
// Video has priority unless the CPU has been stalled CPU_MAX_WAIT cycles.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int RAM_AW       = RAM_AW_DEFAULT,
  parameter int VID_AW       = VID_AW_DEFAULT,
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [VID_AW-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  output logic              vid_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int             CNT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

  state_e              state_q;
  owner_e              owner_q;
  owner_e              grant_s;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                wr_q;
  logic                cpu_elig_s;
  logic                vid_elig_s;
  logic                cpu_wait_s;
  logic                arb_ok_s;

  logic                ram_en_q;
  logic                ram_we_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [7:0]          ram_wdata_q;
  logic                cpu_ack_q;
  logic                vid_valid_q;
  logic [7:0]          cpu_rdata_q;
  logic [7:0]          vid_rdata_q;

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign vid_valid  = vid_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rdata  = vid_rdata_q;
  assign cpu_wait_n = ~(cpu_req & ~cpu_ack_q);

  // Eligibility, grant decision and starvation counter next state.
  // The owner of the access in DATA is excluded so a request still held
  // while its own data is in flight is not granted a second time.
  always_comb begin
    arb_ok_s   = (state_q == IDLE) || (state_q == DATA);
    cpu_elig_s = cpu_req && !cpu_ack_q && !((state_q == DATA) && (owner_q == CPU));
    vid_elig_s = vid_req && !vid_valid_q && !((state_q == DATA) && (owner_q == VID));
    cpu_wait_s = cpu_req && !cpu_ack_q && !((state_q != IDLE) && (owner_q == CPU));

    grant_s = NONE;
    if (!arb_ok_s) begin
      grant_s = NONE;
    end else if (cpu_elig_s && ((cnt_q == CNT_MAX) || !vid_elig_s)) begin
      grant_s = CPU;
    end else if (vid_elig_s) begin
      grant_s = VID;
    end else begin
      grant_s = NONE;
    end

    cnt_d = cnt_q;
    if (!cpu_req || (grant_s == CPU)) begin
      cnt_d = '0;
    end else if (cpu_wait_s && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Access sequencer with registered RAM port and completion outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= 8'h00;
      vid_rdata_q <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      case (state_q)
        ISSUE: begin
          state_q <= DATA;
        end
        IDLE, DATA: begin
          if (state_q == DATA) begin
            if (owner_q == CPU) begin
              cpu_ack_q <= 1'b1;
              if (!wr_q) begin
                cpu_rdata_q <= ram_rdata;
              end
            end else if (owner_q == VID) begin
              vid_valid_q <= 1'b1;
              vid_rdata_q <= ram_rdata;
            end
          end
          if (grant_s != NONE) begin
            state_q  <= ISSUE;
            owner_q  <= grant_s;
            ram_en_q <= 1'b1;
            if (grant_s == CPU) begin
              ram_we_q    <= cpu_we;
              wr_q        <= cpu_we;
              ram_addr_q  <= cpu_addr;
              ram_wdata_q <= cpu_wdata;
            end else begin
              ram_we_q    <= 1'b0;
              wr_q        <= 1'b0;
              ram_addr_q  <= RAM_AW'(vid_addr);
              ram_wdata_q <= 8'h00;
            end
          end else begin
            state_q <= IDLE;
            owner_q <= NONE;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a behavioural RAM.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, vid_req;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [12:0] vid_addr;
  logic [7:0]  cpu_rdata, vid_rdata, ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic        cpu_ack, cpu_wait_n, vid_valid, ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  mem [0:65535];

  int tests = 0;
  int fails = 0;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-first, data one cycle after enable
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        vr;
    logic [12:0] va;
    int          ecyc;      // sample index of cpu_ack (0 = none)
    int          vcyc;      // sample index of vid_valid (0 = none)
    logic [7:0]  erd;       // cpu_rdata in/after ack
    logic [7:0]  evd;       // vid_rdata in valid cycle
    int          en_cnt;
    int          we_cnt;
    logic [15:0] last_addr; // address of the last RAM access
  } vec_t;

  vec_t vecs [8];

  // Drive one transaction set at a negedge and observe 12 following negedges
  task automatic run_txn(input vec_t v, input string tag);
    int cpu_cyc = 0, vid_cyc = 0, en_n = 0, we_n = 0, cack = 0, vval = 0, wlow = 0;
    logic [15:0] laddr = 16'h0000;
    logic [7:0]  crd = 8'h00, vrd = 8'h00;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    vid_req = v.vr; vid_addr = v.va;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      if (ram_en) begin en_n++; laddr = ram_addr; end
      if (ram_we) we_n++;
      if (!cpu_wait_n) wlow++;
      if (cpu_ack) begin cack++; crd = cpu_rdata; if (cpu_cyc == 0) cpu_cyc = s; cpu_req = 1'b0; end
      if (vid_valid) begin vval++; vrd = vid_rdata; if (vid_cyc == 0) vid_cyc = s; vid_req = 1'b0; end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    check({tag, " cpu_ack_cycle"}, cpu_cyc, v.ecyc);
    check({tag, " vid_valid_cycle"}, vid_cyc, v.vcyc);
    check({tag, " cpu_ack_count"}, cack, (v.ecyc != 0) ? 1 : 0);
    check({tag, " vid_valid_count"}, vval, (v.vcyc != 0) ? 1 : 0);
    check({tag, " ram_en_count"}, en_n, v.en_cnt);
    check({tag, " ram_we_count"}, we_n, v.we_cnt);
    check({tag, " last_ram_addr"}, laddr, v.last_addr);
    check({tag, " wait_low_cycles"}, wlow, (v.ecyc != 0) ? v.ecyc - 1 : 0);
    if (v.ecyc != 0) check({tag, " cpu_rdata"}, crd, v.erd);
    if (v.vcyc != 0) check({tag, " vid_rdata"}, vrd, v.evd);
  endtask

  initial begin
    int n_en, n_vv, n_ack, stall, cyc;
    // cr cw  ca        cd     vr  va        ecyc vcyc erd    evd    en we last
    vecs[0] = '{1'b1, 1'b0, 16'h1800, 8'h00, 1'b0, 13'h0000, 3, 0, 8'hA5, 8'h00, 1, 0, 16'h1800};
    vecs[1] = '{1'b1, 1'b1, 16'h0123, 8'h5A, 1'b0, 13'h0000, 3, 0, 8'hA5, 8'h00, 1, 1, 16'h0123};
    vecs[2] = '{1'b1, 1'b0, 16'h0123, 8'h00, 1'b0, 13'h0000, 3, 0, 8'h5A, 8'h00, 1, 0, 16'h0123};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 13'h0000, 0, 3, 8'h00, 8'h3C, 1, 0, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 13'h1FFF, 0, 3, 8'h00, 8'hC3, 1, 0, 16'h1FFF};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b1, 13'h0000, 5, 3, 8'h99, 8'h3C, 2, 0, 16'hFFFF};
    vecs[6] = '{1'b1, 1'b1, 16'h0200, 8'h77, 1'b1, 13'h1FFF, 5, 3, 8'h99, 8'hC3, 2, 1, 16'h0200};
    vecs[7] = '{1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 13'h0000, 3, 0, 8'h77, 8'h00, 1, 0, 16'h0200};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1800] = 8'hA5; mem[16'h0000] = 8'h3C;
    mem[16'h1FFF] = 8'hC3; mem[16'hFFFF] = 8'h99;

    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = 13'h0000;
    reset_n = 1'b0;
    #2;
    check("reset ram_en", ram_en, 1'b0);
    check("reset ram_we", ram_we, 1'b0);
    check("reset acks", {cpu_ack, vid_valid}, 2'b00);
    check("reset wait_n", cpu_wait_n, 1'b1);
    check("reset data outs", {ram_addr, ram_wdata, cpu_rdata, vid_rdata}, 40'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Video request dropped right after its grant: one access, one valid
    vid_addr = 13'h1FFF; vid_req = 1'b1;
    n_en = 0; n_vv = 0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (s == 1) vid_req = 1'b0;
      if (ram_en) n_en++;
      if (vid_valid) n_vv++;
    end
    check("viddrop ram_en_count", n_en, 1);
    check("viddrop vid_valid_count", n_vv, 1);
    check("viddrop vid_rdata", vid_rdata, 8'hC3);

    // CPU request dropped before it was granted (video won): ignored
    vid_addr = 13'h0000; vid_req = 1'b1;
    cpu_addr = 16'h1800; cpu_we = 1'b0; cpu_req = 1'b1;
    n_en = 0; n_ack = 0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (s == 1) cpu_req = 1'b0;
      if (vid_valid) vid_req = 1'b0;
      if (ram_en) n_en++;
      if (cpu_ack) n_ack++;
    end
    check("cpudrop cpu_ack_count", n_ack, 0);
    check("cpudrop ram_en_count", n_en, 1);

    // Continuous video traffic: CPU must still get through in bounded time
    vid_addr = 13'h0000; vid_req = 1'b1;
    cpu_addr = 16'h1800; cpu_we = 1'b0; cpu_req = 1'b1;
    stall = 0; cyc = 0; n_vv = 0;
    for (int s = 1; s <= 30; s++) begin
      @(negedge clk);
      if (vid_valid) n_vv++;
      if (cpu_req && cyc == 0) begin
        if (cpu_ack) begin cyc = s; cpu_req = 1'b0; check("starve cpu_rdata", cpu_rdata, 8'hA5); end
        else if (!cpu_wait_n) stall++;
      end
    end
    vid_req = 1'b0;
    check("starve cpu_acked", (cyc != 0), 1'b1);
    check("starve stall_bound", (stall <= 8), 1'b1);
    check("starve video_served", (n_vv >= 2), 1'b1);
    repeat (4) @(negedge clk);

    // Reset during ISSUE of a CPU read: access abandoned, no ack
    cpu_addr = 16'h1800; cpu_we = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    check("rst_issue ram_en_before", ram_en, 1'b1);
    #2;
    reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("rst_issue ram_en", ram_en, 1'b0);
    check("rst_issue acks", {cpu_ack, vid_valid}, 2'b00);
    check("rst_issue outs", {ram_addr, cpu_rdata}, 24'h0);
    check("rst_issue wait_n", cpu_wait_n, 1'b1);
    n_ack = 0;
    repeat (2) begin @(negedge clk); if (cpu_ack) n_ack++; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); if (cpu_ack || ram_en) n_ack++; end
    check("rst_issue no_activity", n_ack, 0);
    run_txn(vecs[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
